priority_encoder_rr: RTL and testbench

Parametrised, registered priority encoder with fixed-priority and round-robin modes. It generalises the 4-input combinational encoder to N request lines. Requests are sampled through a valid/ready handshake, and a 1-based index code plus a one-hot grant are presented from a single output register stage. It sits between request sources (interrupt lines, arbiter clients) and any consumer that needs a registered winner code with backpressure.

---
 rtl/priority_encoder_pkg.sv | 8 +
 rtl/priority_encoder_rr_if.sv | 14 +
 rtl/priority_encoder_rr_prio_scan.sv | 21 ++
 rtl/priority_encoder_rr.sv | 40 ++++
 tb/tb_priority_encoder_rr.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg: shared mode encodings and pcode width helper
package priority_encoder_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int pcode_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/priority_encoder_rr_if.sv
// priority_encoder_rr_if: request/result handshake bundle for the encoder
interface priority_encoder_rr_if import priority_encoder_pkg::*; #(parameter int N = 8);
  localparam int PW = pcode_width(N);
  logic mode;
  logic in_valid;
  logic in_ready;
  logic [N-1:0] req;
  logic out_valid;
  logic out_ready;
  logic [PW-1:0] out_pcode;
  logic [N-1:0] out_grant;
  modport master(output mode, in_valid, req, out_ready, input in_ready, out_valid, out_pcode, out_grant);
  modport slave(input mode, in_valid, req, out_ready, output in_ready, out_valid, out_pcode, out_grant);
endinterface

// File: rtl/priority_encoder_rr_prio_scan.sv
// prio_scan: highest set bit of a vector as index and one-hot
module prio_scan #(parameter int N = 8) (
  input  logic [N-1:0]         vec,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);
  localparam int IW = $clog2(N);
  // ascending scan so the last set bit seen (the highest) wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        idx = IW'(i);
      end
    end
  end
  assign onehot = found ? (N'(1) << idx) : '0;
endmodule

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: registered fixed/round-robin priority encoder with valid/ready
module priority_encoder_rr import priority_encoder_pkg::*; #(parameter int N = 8) (
  input logic clk,
  input logic reset,
  priority_encoder_rr_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int PW = pcode_width(N);
  logic [IW-1:0] ptr, m_idx, u_idx, w_idx;
  logic [N-1:0] mask, m_oh, u_oh, w_oh;
  logic m_found, u_found, use_m, accept;
  // lines strictly below ptr are searched first; ptr = 0 leaves nothing masked
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = IW'(i) < ptr;
  end
  prio_scan #(.N(N)) u_masked (.vec(bus.req & mask), .found(m_found), .idx(m_idx), .onehot(m_oh));
  prio_scan #(.N(N)) u_full (.vec(bus.req), .found(u_found), .idx(u_idx), .onehot(u_oh));
  assign use_m = (bus.mode == MODE_RR) && m_found;
  assign w_idx = use_m ? m_idx : u_idx;
  assign w_oh = use_m ? m_oh : u_oh;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  // output stage and rotation pointer; a new accept overwrites a beat being consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_pcode <= '0;
      bus.out_grant <= '0;
      ptr <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_pcode <= u_found ? PW'(w_idx) + PW'(1) : '0;
      bus.out_grant <= w_oh;
      if (bus.mode == MODE_RR && u_found) ptr <= w_idx;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: directed checks of fixed, round-robin, backpressure and reset behaviour
module tb_priority_encoder_rr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  priority_encoder_rr_if #(.N(8)) b8 ();
  priority_encoder_rr_if #(.N(2)) b2 ();
  priority_encoder_rr_if #(.N(64)) b64 ();
  priority_encoder_rr #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  priority_encoder_rr #(.N(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  priority_encoder_rr #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(b64));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic m, input logic [7:0] r);
    b8.mode = m;
    b8.req = r;
    b8.in_valid = 1'b1;
    b8.out_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [63:0] e;
    {b8.mode, b8.in_valid, b8.req, b8.out_ready} = '0;
    {b2.mode, b2.in_valid, b2.req, b2.out_ready} = '0;
    {b64.mode, b64.in_valid, b64.req, b64.out_ready} = '0;
    #2;
    chk("rst_valid", b8.out_valid, 0);
    chk("rst_pcode", b8.out_pcode, 0);
    chk("rst_ready", b8.in_ready, 1);
    #10 reset = 1'b0;
    drive8(1'b0, 8'b0000_0000);
    chk("fix0_valid", b8.out_valid, 1);
    chk("fix0_pcode", b8.out_pcode, 0);
    chk("fix0_grant", b8.out_grant, 0);
    drive8(1'b0, 8'b0000_0001);
    chk("fix1_pcode", b8.out_pcode, 1);
    chk("fix1_grant", b8.out_grant, 8'h01);
    drive8(1'b0, 8'b0010_1100);
    chk("fix2c_pcode", b8.out_pcode, 6);
    chk("fix2c_grant", b8.out_grant, 8'h20);
    drive8(1'b0, 8'b1111_1111);
    chk("fixff_pcode", b8.out_pcode, 8);
    chk("fixff_grant", b8.out_grant, 8'h80);
    chk("fix_ptr", dut8.ptr, 0);
    drive8(1'b1, 8'b1000_0101);
    chk("rr1_pcode", b8.out_pcode, 8);
    chk("rr1_ptr", dut8.ptr, 7);
    drive8(1'b1, 8'b1000_0101);
    chk("rr2_pcode", b8.out_pcode, 3);
    chk("rr2_grant", b8.out_grant, 8'h04);
    chk("rr2_ptr", dut8.ptr, 2);
    drive8(1'b1, 8'b1000_0101);
    chk("rr3_pcode", b8.out_pcode, 1);
    chk("rr3_ptr", dut8.ptr, 0);
    drive8(1'b1, 8'b1000_0101);
    chk("rr4_pcode", b8.out_pcode, 8);
    chk("rr4_ptr", dut8.ptr, 7);
    drive8(1'b1, 8'b0000_0000);
    chk("rr0_pcode", b8.out_pcode, 0);
    chk("rr0_grant", b8.out_grant, 0);
    chk("rr0_ptr", dut8.ptr, 7);
    b8.out_ready = 1'b0;
    b8.req = 8'b1000_0101;
    #1;
    chk("bp_in_ready", b8.in_ready, 0);
    step();
    step();
    chk("bp_valid", b8.out_valid, 1);
    chk("bp_pcode", b8.out_pcode, 0);
    chk("bp_ptr", dut8.ptr, 7);
    b8.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", b8.in_ready, 1);
    step();
    chk("bp_next_valid", b8.out_valid, 1);
    chk("bp_next_pcode", b8.out_pcode, 3);
    chk("bp_next_ptr", dut8.ptr, 2);
    b8.in_valid = 1'b0;
    step();
    chk("drain_valid", b8.out_valid, 0);
    drive8(1'b0, 8'b0000_0011);
    chk("sw_fix_pcode", b8.out_pcode, 2);
    chk("sw_fix_ptr", dut8.ptr, 2);
    drive8(1'b1, 8'b0000_0011);
    chk("sw_rr_pcode", b8.out_pcode, 2);
    chk("sw_rr_ptr", dut8.ptr, 1);
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", b8.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", b8.out_valid, 0);
    chk("arst_pcode", b8.out_pcode, 0);
    chk("arst_grant", b8.out_grant, 0);
    chk("arst_ready", b8.in_ready, 1);
    chk("arst_ptr", dut8.ptr, 0);
    #2 reset = 1'b0;
    drive8(1'b1, 8'b1000_0101);
    chk("post_rst_pcode", b8.out_pcode, 8);
    chk("post_rst_ptr", dut8.ptr, 7);
    b8.in_valid = 1'b0;
    b2.in_valid = 1'b1;
    b2.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b2.req = 2'b01 << i;
      step();
      chk($sformatf("n2_walk%0d_pcode", i), b2.out_pcode, 64'(i + 1));
      chk($sformatf("n2_walk%0d_grant", i), b2.out_grant, 64'd1 << i);
    end
    b2.mode = 1'b1;
    b2.req = 2'b11;
    for (int k = 0; k <= 2; k++) begin
      step();
      chk($sformatf("n2_rr%0d_pcode", k), b2.out_pcode, (k == 2) ? 64'd2 : 64'(2 - k));
    end
    b2.in_valid = 1'b0;
    b64.in_valid = 1'b1;
    b64.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      e = 64'd1 << i;
      b64.req = e;
      step();
      chk($sformatf("n64_walk%0d_pcode", i), b64.out_pcode, 64'(i + 1));
      chk($sformatf("n64_walk%0d_grant", i), b64.out_grant, e);
    end
    b64.mode = 1'b1;
    b64.req = '1;
    for (int k = 0; k <= 64; k++) begin
      step();
      chk($sformatf("n64_rr%0d_pcode", k), b64.out_pcode, (k == 64) ? 64'd64 : 64'(64 - k));
    end
    b64.in_valid = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
